// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyphs (bit0=a .. bit6=g) and a
// value-to-glyph helper used by every display block.
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Values above 9 render dark unless hex glyphs are enabled.
  function automatic logic [6:0] seg7_glyph(input logic [3:0] value, input logic hex_en);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
    return (!hex_en && (value > 4'd9)) ? SEG_OFF : seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder: 4-bit value to active-low segments, with a
// dark override for blanked or suppressed digits.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  input  logic       hex_en,
  input  logic       dark,
  output logic [6:0] seg
);

  assign seg = dark ? SEG_OFF : seg7_glyph(value, hex_en);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode display scanner with double-buffered digit data,
// leading-zero suppression and an all-anodes-off guard at each slot start.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int TICK_DIV    = 10000,
  parameter int GUARD       = 2,
  parameter int LZ_SUPPRESS = 1,
  parameter int HEX_EN      = 1
) (
  input  logic                    clk_5MHz,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [6:0]              cathodes,
  output logic                    dp
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]      SLOT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]      GUARD_C   = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0  = NUM_DIGITS'(1);

  logic [CNT_W-1:0]        slot_cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [4*NUM_DIGITS-1:0] pend_dig_r, act_dig_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r, act_dp_r, pend_blank_r, act_blank_r;
  logic                    pend_valid_r;
  logic [NUM_DIGITS-1:0]   anodes_r;
  logic [6:0]              cathodes_r;
  logic                    dp_r, load_ack_r, frame_start_r;

  logic                    slot_end_s, boundary_s, in_guard_s, cur_dark_s;
  logic [NUM_DIGITS-1:0]   lz_mask_s;
  logic [3:0]              cur_val_s;
  logic [6:0]              cur_seg_s;

  assign slot_end_s = (slot_cnt_r == SLOT_LAST);
  assign boundary_s = slot_end_s && (idx_r == IDX_LAST);
  assign in_guard_s = (GUARD > 0) && (slot_cnt_r < GUARD_C);
  assign cur_val_s  = act_dig_r[{idx_r, 2'b00} +: 4];
  assign cur_dark_s = act_blank_r[idx_r] | lz_mask_s[idx_r];

  // Digit i (i >= 1) is suppressed when it and every more significant digit is zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_mask_s  = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero   = upper_zero & (act_dig_r[4*i +: 4] == 4'd0);
      lz_mask_s[i] = upper_zero & (i != 0) & (LZ_SUPPRESS != 0);
    end
  end

  seg7_decode u_decode (
    .value  (cur_val_s),
    .hex_en (HEX_EN != 0),
    .dark   (cur_dark_s),
    .seg    (cur_seg_s)
  );

  // Slot timer and scanned digit index.
  always_ff @(posedge clk_5MHz or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt_r <= {CNT_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
    end else if (slot_end_s) begin
      slot_cnt_r <= {CNT_W{1'b0}};
      idx_r      <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
    end else begin
      slot_cnt_r <= slot_cnt_r + CNT_W'(1);
    end
  end

  // Pending/active double buffer; commit reads pending before a coincident load rewrites it.
  always_ff @(posedge clk_5MHz or negedge reset_n) begin
    if (!reset_n) begin
      pend_dig_r   <= {(4*NUM_DIGITS){1'b0}};
      pend_dp_r    <= {NUM_DIGITS{1'b0}};
      pend_blank_r <= {NUM_DIGITS{1'b0}};
      pend_valid_r <= 1'b0;
      act_dig_r    <= {(4*NUM_DIGITS){1'b0}};
      act_dp_r     <= {NUM_DIGITS{1'b0}};
      act_blank_r  <= {NUM_DIGITS{1'b0}};
    end else begin
      if (boundary_s && pend_valid_r) begin
        act_dig_r   <= pend_dig_r;
        act_dp_r    <= pend_dp_r;
        act_blank_r <= pend_blank_r;
      end
      if (load) begin
        pend_dig_r   <= digits_in;
        pend_dp_r    <= dp_in;
        pend_blank_r <= blank_in;
        pend_valid_r <= 1'b1;
      end else if (boundary_s) begin
        pend_valid_r <= 1'b0;
      end
    end
  end

  // Registered pin drive and status pulses.
  always_ff @(posedge clk_5MHz or negedge reset_n) begin
    if (!reset_n) begin
      anodes_r      <= {NUM_DIGITS{1'b1}};
      cathodes_r    <= SEG_OFF;
      dp_r          <= 1'b1;
      load_ack_r    <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      load_ack_r    <= boundary_s & pend_valid_r;
      frame_start_r <= boundary_s;
      if (in_guard_s) begin
        anodes_r   <= {NUM_DIGITS{1'b1}};
        cathodes_r <= SEG_OFF;
        dp_r       <= 1'b1;
      end else begin
        anodes_r   <= ~(ONE_HOT0 << idx_r);
        cathodes_r <= cur_seg_s;
        dp_r       <= ~act_dp_r[idx_r];
      end
    end
  end

  assign anodes      = anodes_r;
  assign cathodes    = cathodes_r;
  assign dp          = dp_r;
  assign load_ack    = load_ack_r;
  assign frame_start = frame_start_r;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller. It scans `NUM_DIGITS` common-anode digits from a double-buffered 4-bit-per-digit value, with per-digit decimal point and blanking, optional leading-zero suppression, optional hex glyphs and an anti-ghosting guard interval. It replaces the fixed two-digit anode toggler and sits between numeric datapath logic and the board's anode/cathode pins, clocked from the clocking-wizard output.

## Interface
- `NUM_DIGITS`, 8: number of digits scanned, 1..8.
- `TICK_DIV`, 10000: clocks per digit slot; at 5 MHz this gives 500 Hz per slot. Must be ≥ `GUARD`+2.
- `GUARD`, 2: clocks at the start of each slot with all anodes off. 0 disables the guard.
- `LZ_SUPPRESS`, 1: 1 blanks leading zero digits.
- `HEX_EN`, 1: 1 decodes A–F; 0 blanks digit values >9.

Ports:
- `clk_5MHz`, in, 1: the single clock for the block.
- `reset_n`, in, 1: reset, asynchronous and active-low.
- `digits_in`, in, 4*NUM_DIGITS: digit i is `digits_in[4i+3:4i]`. Digit 0 is least significant.
- `dp_in`, in, NUM_DIGITS: decimal point enable per digit, active-high.
- `blank_in`, in, NUM_DIGITS: forces digit i dark, active-high.
- `load`, in, 1: single-cycle strobe that captures `digits_in`/`dp_in`/`blank_in` into the pending buffer.
- `load_ack`, out, 1: one-cycle pulse when the pending buffer is committed to the display.
- `frame_start`, out, 1: one-cycle pulse when the digit index wraps to 0.
- `anodes`, out, NUM_DIGITS: active-low digit enables. Bit i drives digit i.
- `cathodes`, out, 7: active-low segments, with bit0=a through bit6=g.
- `dp`, out, 1: active-low decimal point.

## Operation
- **Slot counter:** `slot_cnt` counts 0..TICK_DIV-1 and then wraps to 0.
  - At `slot_cnt`==TICK_DIV-1, `idx` advances; after NUM_DIGITS-1 it wraps to 0.
  - The cycle in which `idx` wraps is the frame boundary.
- **Buffers:**
  - `pending` holds digits, dp and blank values plus a `pend_valid` flag.
  - `active` holds the same fields and drives the display.
- **Load:** `load`=1 writes `pending` and sets `pend_valid`. A second load before the boundary overwrites the first; the latest load wins.
- **Commit:** at the frame boundary, if `pend_valid` is set, `active`←`pending`, `pend_valid` clears and `load_ack` pulses.
- **Load coinciding with a boundary:** `active` takes the old `pending`. The new data goes into `pending` and `pend_valid` stays set.
- **Leading-zero suppression:** with `LZ_SUPPRESS`=1, digit i (i≥1) is dark when `active` digits i..NUM_DIGITS-1 are all 0. Digit 0 is never suppressed. dp is still shown on a suppressed digit.
- **Dark digit:** its anode is still driven for the slot, with `cathodes`=7'h7F. A dark digit arises from `blank_in`, leading-zero suppression, or an undecodable value.
- **Guard:** while `slot_cnt`<GUARD, `anodes` is all-ones.
- **Drive:** otherwise `anodes`=~(1<<idx), `cathodes`=decode(active digit idx) and `dp`=~active_dp[idx].

## Timing
- All outputs are registered. Each output reflects the `slot_cnt`/`idx`/`active` values of the previous cycle.
- **Reset values:**
  - `anodes` all-ones, `cathodes` 7'h7F, `dp` 1, `load_ack` 0, `frame_start` 0.
  - `slot_cnt` 0, `idx` 0, `active` all zero/clear, `pend_valid` 0.
- Reset takes effect asynchronously, including mid-slot and mid-load. A `load` in the cycle that reset is asserted is lost.
- `frame_start` and `load_ack` are asserted in the cycle after the boundary, so they are coincident with each other.
- **Load latency:**
  - Worst case is NUM_DIGITS*TICK_DIV clocks to commit.
  - The new glyphs for digit 0 appear GUARD+1 cycles after commit.
- `load` is ignored while `reset_n`=0.
- **NUM_DIGITS=1:** `idx` is constant 0, and every slot end is a frame boundary.

## Structure
- **Package `seg7_pkg`:**
  - Segment glyph constants 0–F; for example `SEG_0`=7'b1000000, `SEG_1`=7'b1111001, `SEG_A`=7'b0001000.
  - `SEG_OFF`=7'h7F.
  - A decode function.
- **Sub-module `seg7_decode`:** combinational. Inputs are the 4-bit value, `hex_en` and `dark`; output is 7-bit active-low segments. It is reusable by other display blocks.
- **Top:** slot/index counters, buffers, the leading-zero mask, and the output registers.

## Test plan
All scenarios use NUM_DIGITS=4, TICK_DIV=4 and GUARD=1 unless stated otherwise.
1. **Reset:** drop `reset_n` mid-slot → `anodes`=4'hF, `cathodes`=7'h7F and `dp`=1 with no clock edge; after release, the first slot shows digit 0 as `SEG_0`.
2. **Single load:** load 16'h1234 → exactly one `load_ack`, coincident with `frame_start`. The next frame gives:
   - `anodes` 1110 with 7'b0011001 ("4");
   - then 1101 with 7'b0110000 ("3");
   - and so on, each preceded by one guard cycle at 4'hF.
3. **Leading-zero suppression:** load 16'h0042 → digits 3 and 2 show 7'h7F with their anodes still driven, digit 1 shows "4" and digit 0 shows 7'b0100100. Load 16'h0000 → only digit 0 is lit ("0").
4. **Double load and collision:**
   - Load 16'h1111, then 16'h2222 in the same frame → one ack, and "2222" is displayed.
   - A load coincident with the boundary → the previous pending value commits, and the new value commits at the following boundary.
5. **Hex decode:** digit value 4'hA → `SEG_A` with HEX_EN=1, and 7'h7F with HEX_EN=0.
6. **Decimal point and blank:** `dp_in`=4'b0100 and `blank_in`=4'b0001 → `dp`=0 only during the digit 2 slot, and digit 0 shows 7'h7F while `anodes`=1110.
